sync_fifo_wr_arbiter: RTL

// - Shares the write port of one sync_fifo between NUM_SRC valid/ready requesters.
// - Round-robin, burst-limited grant, with throttling on the FIFO almost-full flag.
// - Sits directly upstream of sync_fifo:
//   - o_valid_m/o_data drive i_valid_s/i_datain.
//   - i_fifo_ready/i_fifo_almostfull come from o_ready_s/o_almostfull.

---
 rtl/sync_fifo_wr_arbiter_pkg.sv | 19 +
 rtl/sync_fifo_wr_arbiter_if.sv | 26 ++
 rtl/sync_fifo_wr_arbiter_rr_pick.sv | 43 ++++
 rtl/sync_fifo_wr_arbiter.sv | 117 +++++++++++
 4 files changed

// File: rtl/sync_fifo_wr_arbiter_pkg.sv
// Shared types and parameter defaults for the sync_fifo write-port arbiter.
// rr_wrap folds an index from the doubled request vector back into 0..n-1.
package sync_fifo_pkg;

    typedef enum logic {
        ARB_IDLE  = 1'b0,
        ARB_GRANT = 1'b1
    } arb_state_e;

    localparam int FIFO_DATA_WIDTH = 32;
    localparam int FIFO_DEPTH      = 8;
    localparam int ARB_NUM_SRC     = 4;
    localparam int ARB_BURST_LEN   = 4;

    function automatic int rr_wrap(input int idx, input int n);
        return (idx >= n) ? idx - n : idx;
    endfunction

endpackage

// File: rtl/sync_fifo_wr_arbiter_if.sv
// Requester and FIFO write-side signals of the arbiter.
// The slave modport is the arbiter's view; master is the sources/FIFO side.
interface sync_fifo_wr_arbiter_if #(
    parameter int NUM_SRC    = 4,
    parameter int DATA_WIDTH = 32
);
    logic [NUM_SRC-1:0]            i_valid;
    logic [NUM_SRC*DATA_WIDTH-1:0] i_data;
    logic [NUM_SRC-1:0]            o_ready;
    logic                          o_valid_m;
    logic [DATA_WIDTH-1:0]         o_data;
    logic                          i_fifo_ready;
    logic                          i_fifo_almostfull;
    logic [NUM_SRC-1:0]            o_grant;
    logic                          o_busy;

    modport slave (
        input  i_valid, i_data, i_fifo_ready, i_fifo_almostfull,
        output o_ready, o_valid_m, o_data, o_grant, o_busy
    );

    modport master (
        output i_valid, i_data, i_fifo_ready, i_fifo_almostfull,
        input  o_ready, o_valid_m, o_data, o_grant, o_busy
    );
endinterface

// File: rtl/sync_fifo_wr_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request strictly after ptr,
// searching circularly, via a masked priority encoder over {req, req}.
module fifo_rr_pick
    import sync_fifo_pkg::*;
#(
    parameter int NUM_SRC = ARB_NUM_SRC,
    parameter int IDX_W   = $clog2(ARB_NUM_SRC)
) (
    input  logic [NUM_SRC-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_SRC-1:0] gnt,
    output logic [IDX_W-1:0]   gnt_idx,
    output logic               any
);

    logic [2*NUM_SRC-1:0] req_dbl;
    logic [2*NUM_SRC-1:0] req_masked;
    logic                 found;

    always_comb begin
        req_dbl = {req, req};
        // Window ptr+1 .. ptr+NUM_SRC of the doubled vector holds every source once,
        // ordered by priority, so the lowest surviving bit is the winner.
        for (int i = 0; i < 2*NUM_SRC; i++) begin
            req_masked[i] = req_dbl[i] && (i > int'(ptr)) && (i <= int'(ptr) + NUM_SRC);
        end

        found   = 1'b0;
        gnt_idx = '0;
        for (int i = 0; i < 2*NUM_SRC; i++) begin
            if (req_masked[i] && !found) begin
                found   = 1'b1;
                gnt_idx = IDX_W'(rr_wrap(i, NUM_SRC));
            end
        end

        for (int k = 0; k < NUM_SRC; k++) begin
            gnt[k] = found && (gnt_idx == IDX_W'(k));
        end
        any = found;
    end

endmodule

// File: rtl/sync_fifo_wr_arbiter.sv
// Round-robin, burst-limited arbiter sharing one sync_fifo write port between
// NUM_SRC valid/ready requesters, with new grants throttled by almost-full.
module sync_fifo_wr_arbiter
    import sync_fifo_pkg::*;
#(
    parameter int NUM_SRC    = ARB_NUM_SRC,
    parameter int DATA_WIDTH = FIFO_DATA_WIDTH,
    parameter int BURST_LEN  = ARB_BURST_LEN
) (
    input logic                   i_clk,
    input logic                   i_rst_n,
    sync_fifo_wr_arbiter_if.slave bus
);

    localparam int IDX_W = $clog2(NUM_SRC);
    localparam int CNT_W = $clog2(BURST_LEN) + 1;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BURST_LEN - 1);
    localparam logic [IDX_W-1:0] PTR_RESET = IDX_W'(NUM_SRC - 1);

    arb_state_e         state_q,    state_d;
    logic [NUM_SRC-1:0] grant_q,    grant_d;
    logic [IDX_W-1:0]   gidx_q,     gidx_d;
    logic [IDX_W-1:0]   rr_ptr_q,   rr_ptr_d;
    logic [CNT_W-1:0]   beat_cnt_q, beat_cnt_d;

    logic [NUM_SRC-1:0]    pick_gnt;
    logic [IDX_W-1:0]      pick_idx;
    logic                  pick_any;
    logic                  busy;
    logic                  src_valid;
    logic                  valid_m;
    logic                  xfer;
    logic [NUM_SRC-1:0]    ready;
    logic [DATA_WIDTH-1:0] data_mux;

    fifo_rr_pick #(
        .NUM_SRC (NUM_SRC),
        .IDX_W   (IDX_W)
    ) u_pick (
        .req     (bus.i_valid),
        .ptr     (rr_ptr_q),
        .gnt     (pick_gnt),
        .gnt_idx (pick_idx),
        .any     (pick_any)
    );

    // Handshake path decodes the grant register directly; no extra cycle.
    always_comb begin
        busy      = (state_q == ARB_GRANT);
        src_valid = |(bus.i_valid & grant_q);
        valid_m   = busy && src_valid;
        ready     = (busy && bus.i_fifo_ready) ? grant_q : '0;
        xfer      = valid_m && bus.i_fifo_ready;
        data_mux  = '0;
        for (int k = 0; k < NUM_SRC; k++) begin
            if (busy && grant_q[k]) begin
                data_mux = data_mux | bus.i_data[k*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        gidx_d     = gidx_q;
        rr_ptr_d   = rr_ptr_q;
        beat_cnt_d = beat_cnt_q;
        case (state_q)
            ARB_IDLE: begin
                // Arbitration only registers the grant; the first beat moves next cycle.
                if (!bus.i_fifo_almostfull && pick_any) begin
                    state_d    = ARB_GRANT;
                    grant_d    = pick_gnt;
                    gidx_d     = pick_idx;
                    beat_cnt_d = '0;
                end
            end
            ARB_GRANT: begin
                if (xfer) begin
                    beat_cnt_d = beat_cnt_q + CNT_W'(1);
                end
                if ((xfer && (beat_cnt_q == LAST_BEAT)) || !src_valid) begin
                    state_d    = ARB_IDLE;
                    grant_d    = '0;
                    rr_ptr_d   = gidx_q;
                    beat_cnt_d = '0;
                end
            end
            default: begin
                state_d = ARB_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q    <= ARB_IDLE;
            grant_q    <= '0;
            gidx_q     <= '0;
            rr_ptr_q   <= PTR_RESET;
            beat_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            gidx_q     <= gidx_d;
            rr_ptr_q   <= rr_ptr_d;
            beat_cnt_q <= beat_cnt_d;
        end
    end

    assign bus.o_ready   = ready;
    assign bus.o_valid_m = valid_m;
    assign bus.o_data    = data_mux;
    assign bus.o_grant   = grant_q;
    assign bus.o_busy    = busy;

endmodule
